// File: rtl/id_ex_stage_if.sv
// Decode-to-execute pipeline register bundle: decode-side inputs, hazard controls,
// execute-side registered outputs and the live ALU flags.
interface id_ex_stage_if #(
    parameter int unsigned WIDTH = 32
);
    logic             StallE;
    logic             FlushE;
    logic             ALUSrcD;
    logic             MemToRegD;
    logic             RegWriteD;
    logic             PlusOneD;
    logic             MemWriteD;
    logic             BranchD;
    logic [3:0]       ALUControlD;
    logic [3:0]       CondD;
    logic [1:0]       FlagWriteD;
    logic [WIDTH-1:0] RD1D;
    logic [WIDTH-1:0] RD2D;
    logic [WIDTH-1:0] ExtImmD;
    logic [3:0]       WA3D;
    logic [3:0]       RA1D;
    logic [3:0]       RA2D;
    logic [3:0]       ALUFlags;

    logic             ALUSrcE;
    logic             MemToRegE;
    logic             PlusOneE;
    logic [3:0]       ALUControlE;
    logic             RegWriteE;
    logic             MemWriteE;
    logic             BranchTakenE;
    logic [WIDTH-1:0] RD1E;
    logic [WIDTH-1:0] RD2E;
    logic [WIDTH-1:0] ExtImmE;
    logic [3:0]       WA3E;
    logic [3:0]       RA1E;
    logic [3:0]       RA2E;
    logic             CondExE;
    logic             ValidE;
    logic [3:0]       Flags;

    modport master (
        output StallE, FlushE, ALUSrcD, MemToRegD, RegWriteD, PlusOneD, MemWriteD, BranchD,
               ALUControlD, CondD, FlagWriteD, RD1D, RD2D, ExtImmD, WA3D, RA1D, RA2D, ALUFlags,
        input  ALUSrcE, MemToRegE, PlusOneE, ALUControlE, RegWriteE, MemWriteE, BranchTakenE,
               RD1E, RD2E, ExtImmE, WA3E, RA1E, RA2E, CondExE, ValidE, Flags
    );

    modport slave (
        input  StallE, FlushE, ALUSrcD, MemToRegD, RegWriteD, PlusOneD, MemWriteD, BranchD,
               ALUControlD, CondD, FlagWriteD, RD1D, RD2D, ExtImmD, WA3D, RA1D, RA2D, ALUFlags,
        output ALUSrcE, MemToRegE, PlusOneE, ALUControlE, RegWriteE, MemWriteE, BranchTakenE,
               RD1E, RD2E, ExtImmE, WA3E, RA1E, RA2E, CondExE, ValidE, Flags
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with conditional-execution evaluation and the
// architectural NZCV flag register.
module id_ex_stage #(
    parameter int unsigned WIDTH = 32
) (
    input logic            clk,
    input logic            rst_n,
    id_ex_stage_if.slave   bus
);
    typedef struct packed {
        logic             alusrc;
        logic             memtoreg;
        logic             regwrite;
        logic             plusone;
        logic             memwrite;
        logic             branch;
        logic [3:0]       alucontrol;
        logic [3:0]       cond;
        logic [1:0]       flagwrite;
        logic [WIDTH-1:0] rd1;
        logic [WIDTH-1:0] rd2;
        logic [WIDTH-1:0] extimm;
        logic [3:0]       wa3;
        logic [3:0]       ra1;
        logic [3:0]       ra2;
        logic             valid;
    } e_regs_t;

    e_regs_t    e_q, e_d, e_load;
    logic [3:0] flags_q, flags_d;
    logic       cond_pass, cond_ex;
    logic       n, z, c, v;

    assign {n, z, c, v} = flags_q;

    always_comb begin
        cond_pass = 1'b0;
        unique case (e_q.cond)
            4'b0000: cond_pass = z;
            4'b0001: cond_pass = !z;
            4'b0010: cond_pass = c;
            4'b0011: cond_pass = !c;
            4'b0100: cond_pass = n;
            4'b0101: cond_pass = !n;
            4'b0110: cond_pass = v;
            4'b0111: cond_pass = !v;
            4'b1000: cond_pass = c & !z;
            4'b1001: cond_pass = !c | z;
            4'b1010: cond_pass = (n == v);
            4'b1011: cond_pass = (n != v);
            4'b1100: cond_pass = !z & (n == v);
            4'b1101: cond_pass = z | (n != v);
            4'b1110: cond_pass = 1'b1;
            4'b1111: cond_pass = 1'b0;
        endcase
    end

    assign cond_ex = cond_pass & e_q.valid;

    assign e_load = '{
        alusrc:     bus.ALUSrcD,
        memtoreg:   bus.MemToRegD,
        regwrite:   bus.RegWriteD,
        plusone:    bus.PlusOneD,
        memwrite:   bus.MemWriteD,
        branch:     bus.BranchD,
        alucontrol: bus.ALUControlD,
        cond:       bus.CondD,
        flagwrite:  bus.FlagWriteD,
        rd1:        bus.RD1D,
        rd2:        bus.RD2D,
        extimm:     bus.ExtImmD,
        wa3:        bus.WA3D,
        ra1:        bus.RA1D,
        ra2:        bus.RA2D,
        valid:      1'b1
    };

    always_comb begin
        e_d     = e_q;
        flags_d = flags_q;
        if (bus.FlushE) begin
            e_d = '0;
        end else if (!bus.StallE) begin
            e_d = e_load;
        end
        // A flush still retires the instruction leaving E, so its flag write survives.
        if (cond_ex && (!bus.StallE || bus.FlushE)) begin
            if (e_q.flagwrite[1]) flags_d[3:2] = bus.ALUFlags[3:2];
            if (e_q.flagwrite[0]) flags_d[1:0] = bus.ALUFlags[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            e_q     <= '0;
            flags_q <= '0;
        end else begin
            e_q     <= e_d;
            flags_q <= flags_d;
        end
    end

    assign bus.ALUSrcE      = e_q.alusrc;
    assign bus.MemToRegE    = e_q.memtoreg;
    assign bus.PlusOneE     = e_q.plusone;
    assign bus.ALUControlE  = e_q.alucontrol;
    assign bus.RegWriteE    = e_q.regwrite & cond_ex;
    assign bus.MemWriteE    = e_q.memwrite & cond_ex;
    assign bus.BranchTakenE = e_q.branch & cond_ex;
    assign bus.RD1E         = e_q.rd1;
    assign bus.RD2E         = e_q.rd2;
    assign bus.ExtImmE      = e_q.extimm;
    assign bus.WA3E         = e_q.wa3;
    assign bus.RA1E         = e_q.ra1;
    assign bus.RA2E         = e_q.ra2;
    assign bus.CondExE      = cond_ex;
    assign bus.ValidE       = e_q.valid;
    assign bus.Flags        = flags_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized self-checking bench for id_ex_stage against a behavioural pipeline model.
module tb_id_ex_stage;
    localparam logic [3:0] ADD = 4'b0100;
    localparam logic [3:0] SUB = 4'b0010;

    typedef struct packed {
        logic        alusrc, memtoreg, regwrite, plusone, memwrite, branch;
        logic [3:0]  alucontrol, cond;
        logic [1:0]  flagwrite;
        logic [31:0] rd1, rd2, extimm;
        logic [3:0]  wa3, ra1, ra2;
    } instr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    id_ex_stage_if #(.WIDTH(32)) bus ();
    id_ex_stage #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    int     errors = 0;
    int     checks = 0;
    instr_t me;
    bit     mvalid;
    logic [3:0] mflags;
    logic [123:0] held;

    // ARM-style: even codes are a base test, odd codes are its negation.
    function automatic bit cond_ok(input logic [3:0] cc, input logic [3:0] f);
        bit nf = f[3], zf = f[2], cf = f[1], vf = f[0];
        bit base;
        case (cc[3:1])
            3'd0:    base = zf;
            3'd1:    base = cf;
            3'd2:    base = nf;
            3'd3:    base = vf;
            3'd4:    base = cf && !zf;
            3'd5:    base = (nf == vf);
            3'd6:    base = !zf && (nf == vf);
            default: base = 1'b1;
        endcase
        return cc[0] ? !base : base;
    endfunction

    function automatic logic [123:0] exp_vec();
        bit ce = mvalid && cond_ok(me.cond, mflags);
        return {me.alusrc, me.memtoreg, me.plusone, me.alucontrol, me.regwrite & ce,
                me.memwrite & ce, me.branch & ce, me.rd1, me.rd2, me.extimm, me.wa3, me.ra1,
                me.ra2, ce, mvalid, mflags};
    endfunction

    function automatic logic [123:0] obs_vec();
        return {bus.ALUSrcE, bus.MemToRegE, bus.PlusOneE, bus.ALUControlE, bus.RegWriteE,
                bus.MemWriteE, bus.BranchTakenE, bus.RD1E, bus.RD2E, bus.ExtImmE, bus.WA3E,
                bus.RA1E, bus.RA2E, bus.CondExE, bus.ValidE, bus.Flags};
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        i.alusrc = 1'($urandom);     i.memtoreg = 1'($urandom); i.regwrite = 1'($urandom);
        i.plusone = 1'($urandom);    i.memwrite = 1'($urandom); i.branch = 1'($urandom);
        i.alucontrol = 4'($urandom); i.cond = 4'($urandom);     i.flagwrite = 2'($urandom);
        i.rd1 = $urandom;            i.rd2 = $urandom;          i.extimm = $urandom;
        i.wa3 = 4'($urandom);        i.ra1 = 4'($urandom);      i.ra2 = 4'($urandom);
        return i;
    endfunction

    function automatic instr_t mk(input logic [3:0] op, input logic [3:0] cc,
                                  input logic [1:0] fw);
        instr_t i = '0;
        i.alucontrol = op;
        i.cond = cc;
        i.flagwrite = fw;
        return i;
    endfunction

    task automatic drive(input instr_t i);
        bus.ALUSrcD = i.alusrc;       bus.MemToRegD = i.memtoreg; bus.RegWriteD = i.regwrite;
        bus.PlusOneD = i.plusone;     bus.MemWriteD = i.memwrite; bus.BranchD = i.branch;
        bus.ALUControlD = i.alucontrol; bus.CondD = i.cond;       bus.FlagWriteD = i.flagwrite;
        bus.RD1D = i.rd1;             bus.RD2D = i.rd2;           bus.ExtImmD = i.extimm;
        bus.WA3D = i.wa3;             bus.RA1D = i.ra1;           bus.RA2D = i.ra2;
    endtask

    // Model of one clock edge: retire the E instruction, then move D into E.
    task automatic tick();
        instr_t din;
        @(posedge clk);
        din = {bus.ALUSrcD, bus.MemToRegD, bus.RegWriteD, bus.PlusOneD, bus.MemWriteD,
               bus.BranchD, bus.ALUControlD, bus.CondD, bus.FlagWriteD, bus.RD1D, bus.RD2D,
               bus.ExtImmD, bus.WA3D, bus.RA1D, bus.RA2D};
        if (!rst_n) begin
            me = '0; mvalid = 0; mflags = '0;
        end else begin
            if (mvalid && cond_ok(me.cond, mflags) && (!bus.StallE || bus.FlushE)) begin
                if (me.flagwrite[1]) mflags[3:2] = bus.ALUFlags[3:2];
                if (me.flagwrite[0]) mflags[1:0] = bus.ALUFlags[1:0];
            end
            if (bus.FlushE) begin
                me = '0; mvalid = 0;
            end else if (!bus.StallE) begin
                me = din; mvalid = 1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0; bus.StallE = 0; bus.FlushE = 1; bus.ALUFlags = 4'hf;
        drive(rand_instr());
        tick(); tick();
        checks++;
        if (obs_vec() !== 124'd0) begin
            errors++; $display("FAIL reset_state got=%h want=0", obs_vec());
        end
        rst_n = 1; bus.FlushE = 0; bus.StallE = 1;
        drive(rand_instr());
        tick();
        checks++;
        if ({bus.RegWriteE, bus.MemWriteE, bus.BranchTakenE, bus.CondExE, bus.ValidE} !== 5'b0)
        begin
            errors++; $display("FAIL idle_gated got=%b want=00000",
                {bus.RegWriteE, bus.MemWriteE, bus.BranchTakenE, bus.CondExE, bus.ValidE});
        end
        bus.StallE = 0;
    endtask

    task automatic test_add();
        instr_t i = mk(ADD, 4'b1110, 2'b00);
        i.regwrite = 1; i.rd1 = 5; i.rd2 = 7; i.wa3 = 3;
        drive(i); bus.ALUFlags = 4'h0;
        tick();
        checks++;
        if ({bus.RegWriteE, bus.RD1E, bus.RD2E, bus.WA3E, bus.CondExE, bus.ValidE} !==
            {1'b1, 32'd5, 32'd7, 4'd3, 1'b1, 1'b1}) begin
            errors++; $display("FAIL add_load rw=%b rd1=%0d rd2=%0d wa3=%0d ce=%b v=%b want 1/5/7/3/1/1",
                bus.RegWriteE, bus.RD1E, bus.RD2E, bus.WA3E, bus.CondExE, bus.ValidE);
        end
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL add_all got=%h want=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_flags_eq();
        instr_t i;
        drive(mk(SUB, 4'b1110, 2'b11));
        tick();
        bus.ALUFlags = 4'b0100;
        i = mk(ADD, 4'b0000, 2'b00); i.regwrite = 1;
        drive(i);
        tick();
        checks++;
        if ({bus.Flags, bus.CondExE, bus.RegWriteE} !== {4'b0100, 1'b1, 1'b1}) begin
            errors++; $display("FAIL eq_taken flags=%b ce=%b rw=%b want 0100/1/1",
                bus.Flags, bus.CondExE, bus.RegWriteE);
        end
        i.cond = 4'b0001;
        drive(i); bus.ALUFlags = 4'($urandom);
        tick();
        checks++;
        if ({bus.Flags, bus.CondExE, bus.RegWriteE} !== {4'b0100, 1'b0, 1'b0}) begin
            errors++; $display("FAIL ne_skipped flags=%b ce=%b rw=%b want 0100/0/0",
                bus.Flags, bus.CondExE, bus.RegWriteE);
        end
    endtask

    task automatic test_lt();
        instr_t st = mk(4'h0, 4'b1011, 2'b00);
        st.memwrite = 1;
        rst_n = 0; tick(); rst_n = 1;
        drive(st);
        tick();
        checks++;
        if ({bus.Flags, bus.CondExE, bus.MemWriteE} !== {4'b0000, 1'b0, 1'b0}) begin
            errors++; $display("FAIL lt_fail flags=%b ce=%b mw=%b want 0000/0/0",
                bus.Flags, bus.CondExE, bus.MemWriteE);
        end
        drive(mk(SUB, 4'b1110, 2'b10));
        tick();
        bus.ALUFlags = 4'b1000;
        drive(st);
        tick();
        checks++;
        if ({bus.Flags, bus.CondExE, bus.MemWriteE} !== {4'b1000, 1'b1, 1'b1}) begin
            errors++; $display("FAIL lt_pass flags=%b ce=%b mw=%b want 1000/1/1",
                bus.Flags, bus.CondExE, bus.MemWriteE);
        end
    endtask

    task automatic test_stall();
        instr_t last;
        drive(mk(ADD, 4'b1110, 2'b11));
        tick();
        held = exp_vec();
        bus.ALUFlags = 4'b1010; bus.StallE = 1;
        for (int k = 0; k < 3; k++) begin
            drive(rand_instr());
            tick();
            checks++;
            if (obs_vec() !== held) begin
                errors++; $display("FAIL stall_hold cyc=%0d got=%h want=%h", k, obs_vec(), held);
            end
        end
        last = rand_instr();
        drive(last); bus.StallE = 0;
        tick();
        checks++;
        if ({bus.Flags, bus.RD1E, bus.WA3E, bus.ValidE} !== {4'b1010, last.rd1, last.wa3, 1'b1})
        begin
            errors++; $display("FAIL stall_release flags=%b rd1=%h wa3=%h v=%b want %b/%h/%h/1",
                bus.Flags, bus.RD1E, bus.WA3E, bus.ValidE, 4'b1010, last.rd1, last.wa3);
        end
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL stall_all got=%h want=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_flush_stall();
        instr_t i = mk(ADD, 4'b1110, 2'b11);
        i.regwrite = 1; i.memwrite = 1; i.branch = 1;
        drive(i);
        tick();
        bus.ALUFlags = 4'b0010; bus.StallE = 1; bus.FlushE = 1;
        drive(rand_instr());
        tick();
        checks++;
        if ({bus.Flags, bus.ValidE, bus.RegWriteE, bus.MemWriteE, bus.BranchTakenE, bus.CondExE}
            !== {4'b0010, 5'b0}) begin
            errors++; $display("FAIL flush_stall flags=%b v=%b rw=%b mw=%b br=%b ce=%b want 0010/0",
                bus.Flags, bus.ValidE, bus.RegWriteE, bus.MemWriteE, bus.BranchTakenE,
                bus.CondExE);
        end
        bus.StallE = 0; bus.FlushE = 0;
    endtask

    task automatic test_reset_in_stall();
        drive(mk(ADD, 4'b1110, 2'b11));
        tick();
        bus.ALUFlags = 4'b1111;
        drive(mk(ADD, 4'b1110, 2'b00));
        tick();
        checks++;
        if (bus.Flags !== 4'b1111) begin
            errors++; $display("FAIL flags_set got=%b want=1111", bus.Flags);
        end
        bus.StallE = 1; rst_n = 0;
        tick();
        checks++;
        if ({bus.Flags, bus.ValidE, bus.CondExE} !== 6'b0) begin
            errors++; $display("FAIL reset_in_stall flags=%b v=%b ce=%b want 0000/0/0",
                bus.Flags, bus.ValidE, bus.CondExE);
        end
        rst_n = 1; bus.StallE = 0;
        drive(rand_instr());
        tick();
        checks++;
        if (obs_vec() !== exp_vec() || bus.ValidE !== 1'b1) begin
            errors++; $display("FAIL post_reset_load got=%h want=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            drive(rand_instr());
            bus.ALUFlags = 4'($urandom);
            bus.StallE = ($urandom_range(0, 3) == 0);
            bus.FlushE = ($urandom_range(0, 7) == 0);
            rst_n = ($urandom_range(0, 31) != 0);
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL random cyc=%0d got=%h want=%h", k, obs_vec(), exp_vec());
            end
        end
        rst_n = 1; bus.StallE = 0; bus.FlushE = 0;
    endtask

    initial begin
        me = '0; mvalid = 0; mflags = '0;
        bus.StallE = 0; bus.FlushE = 0; bus.ALUFlags = '0;
        drive('0);
        test_reset();
        test_add();
        test_flags_eq();
        test_lt();
        test_stall();
        test_flush_stall();
        test_reset_in_stall();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter: WIDTH, 32, datapath width of operand/immediate fields.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 StallE  in  1  hold E register contents this edge.
REQ-005 FlushE  in  1  load bubble into E register this edge.
REQ-006 ALUSrcD, MemToRegD, RegWriteD, PlusOneD, MemWriteD, BranchD  in  1 each  decode-stage control bits.
REQ-007 ALUControlD  in  4  decode-stage ALU operation.
REQ-008 CondD  in  4  instruction condition field.
REQ-009 FlagWriteD  in  2  bit1: update N,Z; bit0: update C,V.
REQ-010 RD1D, RD2D, ExtImmD  in  WIDTH each  operands and extended immediate.
REQ-011 WA3D, RA1D, RA2D  in  4 each  write and read register indices.
REQ-012 ALUFlags  in  4  {N,Z,C,V} from the E-stage ALU, current cycle.
REQ-013 ALUSrcE, MemToRegE, PlusOneE  out  1 each  registered control.
REQ-014 ALUControlE  out  4  registered ALU operation.
REQ-015 RegWriteE, MemWriteE, BranchTakenE  out  1 each  registered control gated by CondExE.
REQ-016 RD1E, RD2E, ExtImmE  out  WIDTH each  registered data.
REQ-017 WA3E, RA1E, RA2E  out  4 each  registered indices (for forwarding/hazard unit).
REQ-018 CondExE  out  1  condition passed for instruction in E.
REQ-019 ValidE  out  1  E holds a real instruction (not bubble).
REQ-020 Flags  out  4  architectural {N,Z,C,V} register.

Function
REQ-021 All state SHALL change only on rising clk; edge priority: reset > FlushE > StallE > load.
REQ-022 Load: every D-suffixed input SHALL be captured into its E register; ValidE SHALL become 1.
REQ-023 StallE=1, FlushE=0: all E registers and Flags SHALL hold.
REQ-024 FlushE=1 (regardless of StallE): all control bits, ALUControlE, CondE, FlagWriteE, ValidE SHALL become 0; data/index fields SHALL become 0.
REQ-025 CondExE SHALL be combinational from registered CondE and Flags: EQ 0000 Z; NE 0001 !Z; CS 0010 C; CC 0011 !C; MI 0100 N; PL 0101 !N; VS 0110 V; VC 0111 !V; HI 1000 C&!Z; LS 1001 !C|Z; GE 1010 N==V; LT 1011 N!=V; GT 1100 !Z&(N==V); LE 1101 Z|(N!=V); AL 1110 1; 1111 0.
REQ-026 CondExE SHALL be forced 0 when ValidE=0.
REQ-027 RegWriteE, MemWriteE, BranchTakenE SHALL equal their registered bits AND CondExE; other control outputs ungated.
REQ-028 Flags update at edge when ValidE=1, CondExE=1, StallE=0: FlagWriteE[1] loads N,Z from ALUFlags[3:2]; FlagWriteE[0] loads C,V from ALUFlags[1:0]; independent per pair.
REQ-029 FlushE at same edge SHALL NOT suppress the flag update of the instruction currently leaving E.
REQ-030 Latency: D inputs appear on E outputs exactly one cycle after a load edge; CondExE for that instruction valid in the same cycle.
REQ-031 Flag update from instruction k SHALL be visible to CondExE of instruction k+1 in its E cycle (no extra bubble).

Reset
REQ-032 rst_n=0 at an edge SHALL clear every E register, ValidE, and Flags to 0, overriding StallE/FlushE.
REQ-033 Reset asserted mid-stall SHALL discard the held instruction; after release first load edge behaves per REQ-022.
REQ-034 Between reset and first load, all gated outputs SHALL be 0.

Verification
REQ-035 Reset then load ADD (ALUControlD=ADD, RegWriteD=1, CondD=1110, RD1D=5, RD2D=7, WA3D=3) -> next cycle RegWriteE=1, RD1E=5, RD2E=7, WA3E=3, CondExE=1, ValidE=1.
REQ-036 Load SUB, FlagWriteD=11, CondD=1110, ALUFlags=0100 in E -> Flags=0100; next instruction CondD=0000 (EQ), RegWriteD=1 -> CondExE=1, RegWriteE=1; same with CondD=0001 -> RegWriteE=0.
REQ-037 Flags=0000, load STR with CondD=1011 (LT), MemWriteD=1 -> CondExE=0, MemWriteE=0; Flags then set 1000 via FlagWriteD=10 -> LT instruction MemWriteE=1.
REQ-038 StallE=1 for 3 cycles while D inputs change each cycle -> E outputs and Flags unchanged; no flag update repeated; release -> latest D captured.
REQ-039 FlushE=1 and StallE=1 same edge with E holding flag-setting ADD (ALUFlags=0010) -> Flags=0010, next cycle ValidE=0, all gated outputs 0.
REQ-040 rst_n=0 during stall with Flags=1111 -> next cycle Flags=0000, ValidE=0, CondExE=0.
